// File: rtl/cdb_arbiter_if.sv
// Result-write bus between the functional units and the CDB arbiter:
// per-FU result handshake plus the registered CDB broadcast.
`ifndef ROB_SIZE
`define ROB_SIZE 4
`endif
`ifndef XLEN
`define XLEN 32
`endif

interface cdb_arbiter_if #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = `ROB_SIZE,
  parameter int DATA_W = `XLEN
);
  logic [NUM_FU-1:0]        fu_valid_i;
  logic [NUM_FU*TAG_W-1:0]  fu_tag_i;
  logic [NUM_FU*DATA_W-1:0] fu_value_i;
  logic [NUM_FU-1:0]        fu_ready_o;
  logic                     cdb_valid_o;
  logic [TAG_W-1:0]         cdb_tag_o;
  logic [DATA_W-1:0]        cdb_value_o;

  modport master (
    output fu_valid_i, fu_tag_i, fu_value_i,
    input  fu_ready_o, cdb_valid_o, cdb_tag_o, cdb_value_o
  );

  modport slave (
    input  fu_valid_i, fu_tag_i, fu_value_i,
    output fu_ready_o, cdb_valid_o, cdb_tag_o, cdb_value_o
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the ROB CDB write port among NUM_FU one-entry result buffers.
// Optional grant/conflict statistics counters enabled by defining CDB_ARB_STATS_EN.
`ifndef ROB_SIZE
`define ROB_SIZE 4
`endif
`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = `ROB_SIZE,
  parameter int DATA_W = `XLEN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_i,
  input  logic          flush_i,
  cdb_arbiter_if.slave  bus
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0]   stat_grant_o,
  output logic [31:0]   stat_conflict_o
`endif
);

  localparam int unsigned N     = NUM_FU;
  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] r_occ;
  logic [TAG_W-1:0]  r_tag [NUM_FU];
  logic [DATA_W-1:0] r_val [NUM_FU];
  logic [PTR_W-1:0]  r_ptr;
  logic              r_cdb_valid;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_value;

  logic [NUM_FU-1:0] w_grant;
  logic [NUM_FU-1:0] w_ready;
  logic [PTR_W-1:0]  w_win;
  logic              w_any;

  // Scan from the pointer, wrapping; the first occupied buffer wins.
  always_comb begin
    int unsigned idx;
    w_grant = '0;
    w_win   = '0;
    w_any   = 1'b0;
    idx     = 0;
    if (!stall_i && !flush_i) begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = (int'(r_ptr) + k) % N;
        if (!w_any && r_occ[idx]) begin
          w_any        = 1'b1;
          w_win        = PTR_W'(idx);
          w_grant[idx] = 1'b1;
        end
      end
    end
  end

  assign w_ready = ~r_occ | w_grant;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ       <= '0;
      r_ptr       <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_value <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        r_tag[i] <= '0;
        r_val[i] <= '0;
      end
    end else if (flush_i) begin
      r_occ       <= '0;
      r_ptr       <= '0;
      r_cdb_valid <= 1'b0;
    end else begin
      r_cdb_valid <= w_any;
      if (w_any) begin
        r_cdb_tag   <= r_tag[w_win];
        r_cdb_value <= r_val[w_win];
        r_ptr       <= (w_win == PTR_W'(N - 1)) ? '0 : w_win + 1'b1;
      end
      // A refill in the grant cycle wins over the free, keeping the buffer occupied.
      for (int unsigned i = 0; i < N; i++) begin
        if (bus.fu_valid_i[i] && w_ready[i]) begin
          r_occ[i] <= 1'b1;
          r_tag[i] <= bus.fu_tag_i[i*TAG_W +: TAG_W];
          r_val[i] <= bus.fu_value_i[i*DATA_W +: DATA_W];
        end else if (w_grant[i]) begin
          r_occ[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.fu_ready_o  = w_ready;
  assign bus.cdb_valid_o = r_cdb_valid;
  assign bus.cdb_tag_o   = r_cdb_tag;
  assign bus.cdb_value_o = r_cdb_value;

`ifdef CDB_ARB_STATS_EN
  logic [31:0] r_stat_grant;
  logic [31:0] r_stat_conflict;
  logic        w_conflict;

  assign w_conflict = ($countones(r_occ) >= 2) && !stall_i && !flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_grant    <= '0;
      r_stat_conflict <= '0;
    end else if (flush_i) begin
      r_stat_grant    <= '0;
      r_stat_conflict <= '0;
    end else begin
      if (w_any && (r_stat_grant != '1))
        r_stat_grant <= r_stat_grant + 32'd1;
      if (w_conflict && (r_stat_conflict != '1))
        r_stat_conflict <= r_stat_conflict + 32'd1;
    end
  end

  assign stat_grant_o    = r_stat_grant;
  assign stat_conflict_o = r_stat_conflict;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by randomized
// traffic, all compared against a per-FU buffer / round-robin reference model.
module tb_cdb_arbiter;

  localparam int NF = 4;
  localparam int TW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic stall_i;
  logic flush_i;

  int n_pass = 0;
  int n_chk  = 0;

  cdb_arbiter_if #(.NUM_FU(NF), .TAG_W(TW), .DATA_W(DW)) bus ();

`ifdef CDB_ARB_STATS_EN
  logic [31:0] stat_grant;
  logic [31:0] stat_conflict;
`endif

  cdb_arbiter #(.NUM_FU(NF), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall_i),
    .flush_i (flush_i),
    .bus     (bus)
`ifdef CDB_ARB_STATS_EN
    ,
    .stat_grant_o    (stat_grant),
    .stat_conflict_o (stat_conflict)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: what each FU's holding buffer contains, where the
  // round-robin search starts, and what the CDB should be showing.
  bit           m_occ [NF];
  logic [TW-1:0] m_tag [NF];
  logic [DW-1:0] m_val [NF];
  int           m_ptr;
  bit           e_valid;
  logic [TW-1:0] e_tag;
  logic [DW-1:0] e_val;
  logic [NF-1:0] last_acc;

  // Random FU sources: a result stays presented until it is accepted.
  bit           pend [NF];
  logic [TW-1:0] ptag [NF];
  logic [DW-1:0] pval [NF];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic put(input int i, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
    bus.fu_valid_i[i]         = v;
    bus.fu_tag_i[i*TW +: TW]  = t;
    bus.fu_value_i[i*DW +: DW] = d;
  endtask

  task automatic clear_inputs();
    bus.fu_valid_i = '0;
    bus.fu_tag_i   = '0;
    bus.fu_value_i = '0;
    stall_i        = 1'b0;
    flush_i        = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      m_occ[i] = 0;
      m_tag[i] = '0;
      m_val[i] = '0;
      pend[i]  = 0;
    end
    m_ptr   = 0;
    e_valid = 0;
    e_tag   = '0;
    e_val   = '0;
  endtask

  // Asserts reset (asynchronously, wherever we are) and checks the reset state.
  task automatic do_reset();
    clear_inputs();
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 32'(bus.cdb_valid_o), 32'd0);
    chk("rst_tag",   32'(bus.cdb_tag_o),   32'd0);
    chk("rst_value", bus.cdb_value_o,      32'd0);
    chk("rst_ready", 32'(bus.fu_ready_o),  32'hF);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock with the inputs currently driven; starts and ends at a negedge.
  task automatic step();
    int w;
    logic [NF-1:0] rdy;
    logic [NF-1:0] v;
    logic [NF*TW-1:0] tg;
    logic [NF*DW-1:0] vl;
    #1;
    w = -1;
    if (!stall_i && !flush_i)
      for (int k = 0; k < NF; k++)
        if (w < 0 && m_occ[(m_ptr + k) % NF]) w = (m_ptr + k) % NF;
    for (int i = 0; i < NF; i++) rdy[i] = !m_occ[i] || (w == i);
    chk("ready", 32'(bus.fu_ready_o), 32'(rdy));
    v  = bus.fu_valid_i;
    tg = bus.fu_tag_i;
    vl = bus.fu_value_i;
    @(posedge clk);
    last_acc = v & rdy;
    if (flush_i) begin
      for (int i = 0; i < NF; i++) m_occ[i] = 0;
      m_ptr   = 0;
      e_valid = 0;
    end else begin
      e_valid = (w >= 0);
      if (w >= 0) begin
        e_tag    = m_tag[w];
        e_val    = m_val[w];
        m_occ[w] = 0;
        m_ptr    = (w + 1) % NF;
      end
      for (int i = 0; i < NF; i++)
        if (last_acc[i]) begin
          m_occ[i] = 1;
          m_tag[i] = tg[i*TW +: TW];
          m_val[i] = vl[i*DW +: DW];
        end
    end
    @(negedge clk);
    chk("cdb_valid", 32'(bus.cdb_valid_o), 32'(e_valid));
    chk("cdb_tag",   32'(bus.cdb_tag_o),   32'(e_tag));
    chk("cdb_value", bus.cdb_value_o,      e_val);
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    last_acc = '0;
    @(negedge clk);

    // Reset state
    do_reset();

    // Single FU: FU2 tag 5 / value 256
    put(2, 1'b1, 4'd5, 32'd256);
    step();
    put(2, 1'b0, '0, '0);
    step();
    chk("single_valid", 32'(bus.cdb_valid_o), 32'd1);
    chk("single_tag",   32'(bus.cdb_tag_o),   32'd5);
    chk("single_value", bus.cdb_value_o,      32'd256);
    step();
    chk("single_once", 32'(bus.cdb_valid_o), 32'd0);

    // Round robin over all four FUs from ptr 0
    do_reset();
    for (int i = 0; i < NF; i++) put(i, 1'b1, 4'(i + 1), 32'((i + 1) * 16));
    step();
    for (int i = 0; i < NF; i++) put(i, 1'b0, '0, '0);
    for (int i = 0; i < NF; i++) begin
      step();
      chk("rr_tag",   32'(bus.cdb_tag_o),   32'(i + 1));
      chk("rr_value", bus.cdb_value_o,      32'((i + 1) * 16));
    end
    step();
    chk("rr_idle", 32'(bus.cdb_valid_o), 32'd0);

    // Fairness: FU0 and FU3 hold valid continuously (ptr is back at 0)
    put(0, 1'b1, 4'd1, 32'hA0);
    put(3, 1'b1, 4'd3, 32'hA3);
    for (int j = 1; j <= 8; j++) begin
      step();
      if (j >= 2) chk("fair_tag", 32'(bus.cdb_tag_o), (j % 2 == 0) ? 32'd1 : 32'd3);
    end
    put(0, 1'b0, '0, '0);
    put(3, 1'b0, '0, '0);
    step();
    step();
    step();

    // Stall with FU1 (tag 7) and FU2 (tag 9) occupied
    do_reset();
    stall_i = 1'b1;
    put(1, 1'b1, 4'd7, 32'h70);
    put(2, 1'b1, 4'd9, 32'h90);
    step();
    put(1, 1'b0, '0, '0);
    put(2, 1'b0, '0, '0);
    for (int j = 0; j < 2; j++) begin
      step();
      chk("stall_quiet", 32'(bus.cdb_valid_o), 32'd0);
    end
    stall_i = 1'b0;
    step();
    chk("stall_first", 32'(bus.cdb_tag_o), 32'd7);
    step();
    chk("stall_second", 32'(bus.cdb_tag_o), 32'd9);

    // Flush: one buffer left occupied plus an FU3 handshake in the flush cycle
    do_reset();
    for (int i = 0; i < 3; i++) put(i, 1'b1, 4'(i + 10), 32'(i + 100));
    step();
    for (int i = 0; i < 3; i++) put(i, 1'b0, '0, '0);
    step();
    step();
    flush_i = 1'b1;
    put(3, 1'b1, 4'd15, 32'hF3);
    step();
    chk("flush_valid", 32'(bus.cdb_valid_o), 32'd0);
    flush_i = 1'b0;
    put(3, 1'b0, '0, '0);
    step();
    step();
    chk("flush_drained", 32'(bus.cdb_valid_o), 32'd0);
    put(1, 1'b1, 4'd11, 32'd77);
    put(3, 1'b1, 4'd13, 32'd99);
    step();
    put(1, 1'b0, '0, '0);
    put(3, 1'b0, '0, '0);
    step();
    chk("flush_ptr0_tag", 32'(bus.cdb_tag_o), 32'd11);
    chk("flush_new_val",  bus.cdb_value_o,    32'd77);
    step();

    // Randomized traffic with stalls and flushes
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NF; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 55) begin
          pend[i] = 1;
          ptag[i] = 4'($urandom);
          pval[i] = $urandom;
        end
        put(i, pend[i], pend[i] ? ptag[i] : '0, pend[i] ? pval[i] : '0);
      end
      stall_i = ($urandom_range(0, 99) < 15);
      flush_i = ($urandom_range(0, 99) < 4);
      step();
      for (int i = 0; i < NF; i++) if (last_acc[i]) pend[i] = 0;
    end

    // Reset mid-operation with buffers occupied
    for (int i = 0; i < NF; i++) put(i, 1'b1, 4'(i + 4), 32'(i + 500));
    stall_i = 1'b0;
    flush_i = 1'b0;
    step();
    step();
    do_reset();
    step();
    chk("post_rst_idle", 32'(bus.cdb_valid_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
